// File: rtl/cpu_oci_trace_monitor.sv
// cpu_oci_trace_monitor
// Buffers tagged debug-trace frames, checks that the tags run in sequence,
// drains the buffered frames on request, and keeps saturating statistics.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   dct_valid         qualifies dct_buffer / dct_count
//   dct_buffer        trace frame payload (DATA_W)
//   dct_count         frame sequence tag (COUNT_W), increments mod 2^COUNT_W
//   test_ending       level, requests CAPTURE -> DRAIN
//   test_has_ended    level, forces DONE from any state
//   rd_ready          downstream accepts the drained head frame
//   rd_valid          head frame available (combinational)
//   rd_data, rd_tag   head payload / tag, first-word-fall-through (combinational)
//   frame_count       frames seen in CAPTURE, saturating
//   seq_err_count     tag discontinuities, saturating
//   overflow          sticky, a frame was dropped on a full FIFO
//   fill_level        current FIFO occupancy
//   state             CAPTURE=0, DRAIN=1, DONE=2
//   done              high while in DONE
//
// Optional build macro: CPU_OCI_TRACE_REPORT_EN compiles in simulation-only
// $display reporting of sequence errors, drops and an end-of-run summary.
// Port behaviour is identical with or without it.
module cpu_oci_trace_monitor #(
  parameter int unsigned DATA_W  = 30,
  parameter int unsigned COUNT_W = 4,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned STAT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dct_valid,
  input  logic [DATA_W-1:0]        dct_buffer,
  input  logic [COUNT_W-1:0]       dct_count,
  input  logic                     test_ending,
  input  logic                     test_has_ended,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic [COUNT_W-1:0]       rd_tag,
  output logic [STAT_W-1:0]        frame_count,
  output logic [STAT_W-1:0]        seq_err_count,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [1:0]               state,
  output logic                     done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;
  localparam int unsigned EW = COUNT_W + DATA_W;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [EW-1:0]      mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               first_seen;
  logic [COUNT_W-1:0] exp_tag;
  logic [EW-1:0]      head;

  logic capture;
  logic full;
  logic push;
  logic pop;
  logic seq_mismatch;

  assign capture      = (state_q == CAPTURE) && dct_valid;
  assign full         = (fill_level == FW'(DEPTH));
  assign push         = capture && !full;
  assign pop          = rd_valid && rd_ready;
  assign seq_mismatch = capture && first_seen && (dct_count != exp_tag);

  // Head decode; forced to zero when empty so stale RAM never shows.
  assign rd_valid          = (state_q == DRAIN) && (fill_level != '0);
  assign head              = mem[rd_ptr];
  assign {rd_tag, rd_data} = (fill_level != '0) ? head : '0;
  assign state             = state_q;

  // Next-state logic; test_has_ended overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CAPTURE: if (test_ending) state_d = DRAIN;
      DRAIN:   if ((fill_level == '0) || ((fill_level == FW'(1)) && pop)) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = CAPTURE;
    endcase
    if (test_has_ended) state_d = DONE;
  end

  // State, statistics, sequence tracking and FIFO pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= CAPTURE;
      done          <= 1'b0;
      frame_count   <= '0;
      seq_err_count <= '0;
      overflow      <= 1'b0;
      fill_level    <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      first_seen    <= 1'b0;
      exp_tag       <= '0;
    end else begin
      state_q <= state_d;
      done    <= (state_d == DONE);
      if (capture) begin
        if (frame_count != '1) frame_count <= frame_count + STAT_W'(1);
        first_seen <= 1'b1;
        // Always resync to the received tag so one gap counts as one error.
        exp_tag    <= dct_count + COUNT_W'(1);
        if (full) overflow <= 1'b1;
      end
      if (seq_mismatch && (seq_err_count != '1))
        seq_err_count <= seq_err_count + STAT_W'(1);
      // Push only happens in CAPTURE and pop only in DRAIN.
      if (push) begin
        wr_ptr     <= wr_ptr + AW'(1);
        fill_level <= fill_level + FW'(1);
      end else if (pop) begin
        rd_ptr     <= rd_ptr + AW'(1);
        fill_level <= fill_level - FW'(1);
      end
    end
  end

  // Frame storage.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {dct_count, dct_buffer};
  end

`ifdef CPU_OCI_TRACE_REPORT_EN
  always @(posedge clk) begin
    if (!reset) begin
      if (seq_mismatch)
        $display("[%0t] cpu_oci_trace_monitor: sequence error, expected tag %0d received %0d",
                 $time, exp_tag, dct_count);
      if (capture && full)
        $display("[%0t] cpu_oci_trace_monitor: frame dropped, FIFO full (tag %0d)",
                 $time, dct_count);
      if ((state_q != DONE) && (state_d == DONE))
        $display("[%0t] cpu_oci_trace_monitor: done, frames=%0d seq_errs=%0d overflow=%0d residual=%0d",
                 $time, frame_count, seq_err_count, overflow, fill_level);
    end
  end
`endif

endmodule

// File: tb/tb_cpu_oci_trace_monitor.sv
module tb_cpu_oci_trace_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        dct_valid;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        test_has_ended;
  logic        rd_ready;
  logic        rd_valid;
  logic [29:0] rd_data;
  logic [3:0]  rd_tag;
  logic [15:0] frame_count;
  logic [15:0] seq_err_count;
  logic        overflow;
  logic [4:0]  fill_level;
  logic [1:0]  state;
  logic        done;

  int n_assert = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  int model_fill = 0;
  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  cpu_oci_trace_monitor dut (
    .clk(clk), .reset(reset), .dct_valid(dct_valid), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .test_ending(test_ending), .test_has_ended(test_has_ended),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_tag(rd_tag),
    .frame_count(frame_count), .seq_err_count(seq_err_count), .overflow(overflow),
    .fill_level(fill_level), .state(state), .done(done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; dct_valid = 1'b0; dct_buffer = '0; dct_count = '0;
    test_ending = 1'b0; test_has_ended = 1'b0; rd_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    exp_q.delete();
    model_fill = 0;
    n_pops = 0;
  endtask

  task automatic push(input logic [3:0] tag, input logic [29:0] data);
    dct_valid = 1'b1; dct_count = tag; dct_buffer = data;
    if (model_fill < 16) begin
      exp_q.push_back({tag, data});
      model_fill++;
    end
    step();
    dct_valid = 1'b0;
  endtask

  // Waits for done with a bound; returns the number of cycles spent.
  task automatic wait_done(input int limit, output int cycles);
    cycles = 0;
    while (!done && cycles < limit) begin
      step();
      cycles++;
    end
    if (!done) chk("done_timeout", 64'(done), 64'd1);
  endtask

  // Scoreboard monitor: compares each accepted beat with the queue head
  // and checks the head stays stable while stalled.
  logic        stalled = 1'b0;
  logic [33:0] held;
  always @(negedge clk) begin
    if (reset || !rd_valid) begin
      stalled = 1'b0;
    end else begin
      if (stalled) chk("stall_stable", 64'({rd_tag, rd_data}), 64'(held));
      if (rd_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 64'({rd_tag, rd_data}), 64'h0);
        else chk("drain_beat", 64'({rd_tag, rd_data}), 64'(exp_q.pop_front()));
        n_pops++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = {rd_tag, rd_data};
      end
    end
  end

  initial begin
    int cyc;
    bit pat[4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    // Reset state
    do_reset();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", 64'({rd_tag, rd_data}), 64'd0);
    chk("rst_fill", 64'(fill_level), 64'd0);
    chk("rst_frames", 64'(frame_count), 64'd0);
    chk("rst_seq", 64'(seq_err_count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);

    // Five in-order frames, full-throughput drain
    for (int i = 0; i < 5; i++) push(4'(3 + i), 30'(1 + i));
    chk("t1_fill", 64'(fill_level), 64'd5);
    chk("t1_frames", 64'(frame_count), 64'd5);
    chk("t1_seq", 64'(seq_err_count), 64'd0);
    test_ending = 1'b1; rd_ready = 1'b1;
    step();
    test_ending = 1'b0;
    chk("t1_drain_state", 64'(state), 64'd1);
    wait_done(40, cyc);
    chk("t1_done_latency", 64'(cyc), 64'd5);
    chk("t1_pops", 64'(n_pops), 64'd5);
    chk("t1_q_empty", 64'(exp_q.size()), 64'd0);
    chk("t1_state_done", 64'(state), 64'd2);
    chk("t1_rd_valid", 64'(rd_valid), 64'd0);
    chk("t1_fill_end", 64'(fill_level), 64'd0);

    // Tag wrap is legal; a gap costs exactly one error; stalled drain
    do_reset();
    push(4'd14, 30'h10); push(4'd15, 30'h11); push(4'd0, 30'h12); push(4'd1, 30'h13);
    chk("t2_wrap_seq", 64'(seq_err_count), 64'd0);
    push(4'd2, 30'h14); push(4'd4, 30'h15); push(4'd5, 30'h16);
    chk("t2_gap_seq", 64'(seq_err_count), 64'd1);
    chk("t2_frames", 64'(frame_count), 64'd7);
    test_ending = 1'b1; rd_ready = 1'b0;
    step();
    test_ending = 1'b0;
    cyc = 0;
    while (!done && cyc < 60) begin
      rd_ready = pat[cyc % 4];
      step();
      cyc++;
    end
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_pops", 64'(n_pops), 64'd7);
    chk("t2_q_empty", 64'(exp_q.size()), 64'd0);

    // Overflow: 20 frames into 16 entries
    do_reset();
    for (int i = 0; i < 20; i++) push(4'(i), 30'(100 + i));
    chk("t3_fill", 64'(fill_level), 64'd16);
    chk("t3_ovf", 64'(overflow), 64'd1);
    chk("t3_frames", 64'(frame_count), 64'd20);
    chk("t3_seq", 64'(seq_err_count), 64'd0);
    test_ending = 1'b1; rd_ready = 1'b1;
    step();
    test_ending = 1'b0;
    wait_done(60, cyc);
    chk("t3_pops", 64'(n_pops), 64'd16);
    chk("t3_q_empty", 64'(exp_q.size()), 64'd0);

    // Forced termination mid-drain freezes the FIFO
    do_reset();
    for (int i = 0; i < 8; i++) push(4'(i), 30'(200 + i));
    test_ending = 1'b1; rd_ready = 1'b1;
    step();
    test_ending = 1'b0;
    step(); step(); step();
    rd_ready = 1'b0; test_has_ended = 1'b1;
    chk("t4_pops3", 64'(n_pops), 64'd3);
    step();
    chk("t4_state", 64'(state), 64'd2);
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_fill", 64'(fill_level), 64'd5);
    chk("t4_rd_valid", 64'(rd_valid), 64'd0);
    test_has_ended = 1'b0; rd_ready = 1'b1;
    step(); step(); step();
    chk("t4_fill_frozen", 64'(fill_level), 64'd5);
    chk("t4_still_done", 64'(state), 64'd2);

    // Reset while draining, then a fresh first frame
    do_reset();
    for (int i = 0; i < 4; i++) push(4'(7 + i), 30'(300 + i));
    test_ending = 1'b1; rd_ready = 1'b0;
    step();
    test_ending = 1'b0;
    chk("t5_drain", 64'(state), 64'd1);
    reset = 1'b1;
    step();
    exp_q.delete(); model_fill = 0;
    chk("t5_state", 64'(state), 64'd0);
    chk("t5_fill", 64'(fill_level), 64'd0);
    chk("t5_rd_valid", 64'(rd_valid), 64'd0);
    chk("t5_rd_data", 64'({rd_tag, rd_data}), 64'd0);
    chk("t5_frames", 64'(frame_count), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    reset = 1'b0;
    push(4'd9, 30'h3ff);
    chk("t5_first_seq", 64'(seq_err_count), 64'd0);
    chk("t5_first_frames", 64'(frame_count), 64'd1);
    chk("t5_first_fill", 64'(fill_level), 64'd1);
    push(4'd3, 30'h3fe);
    chk("t5_second_seq", 64'(seq_err_count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
